// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// stopwatch_lap_ctrl: run/pause/lap stopwatch with tick prescaler and circular lap memory.
// Optional macro STOPWATCH_WRAP_EN: count wraps to 0 at all-ones instead of saturating.
module stopwatch_lap_ctrl #(
  parameter int CNT_W     = 16,
  parameter int LAP_DEPTH = 4,
  parameter int TICK_DIV  = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_pause,
  input  logic                         clear_req,
  input  logic                         lap_req,
  input  logic [$clog2(LAP_DEPTH)-1:0] lap_sel,
  output logic                         running,
  output logic                         hold,
  output logic [CNT_W-1:0]             count,
  output logic [CNT_W-1:0]             disp,
  output logic [CNT_W-1:0]             lap_data,
  output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
  output logic                         ovf
);

  localparam int LW = $clog2(LAP_DEPTH);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW:0]       lap_cnt_q, lap_cnt_d;
  logic              ovf_q, ovf_d;
  logic              lap_we;
  logic              active;
  logic [CNT_W-1:0]  lap_mem_q [LAP_DEPTH];
  logic [LW-1:0]     last_idx;
  logic [LW-1:0]     rd_idx;

  assign active = (state_q == S_RUN) || (state_q == S_HOLD);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    lap_cnt_d = lap_cnt_q;
    ovf_d     = ovf_q;
    lap_we    = 1'b0;
    if (clear_req) begin
      state_d   = S_IDLE;
      presc_d   = '0;
      count_d   = '0;
      wr_ptr_d  = '0;
      lap_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (start_pause) begin
        state_d = active ? S_PAUSE : S_RUN;
      end else if (lap_req) begin
        if (state_q == S_RUN) begin
          state_d  = S_HOLD;
          lap_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (lap_cnt_q != (LW+1)'(LAP_DEPTH)) lap_cnt_d = lap_cnt_q + 1'b1;
        end else if (state_q == S_HOLD) begin
          state_d = S_RUN;
        end
      end
      // Ticking follows the state held during this cycle, so a same-cycle pause still counts.
      if (active) begin
        if (presc_q == PW'(TICK_DIV - 1)) begin
          presc_d = '0;
          if (&count_q) begin
            ovf_d = 1'b1;
`ifdef STOPWATCH_WRAP_EN
            count_d = '0;
`else
            count_d = count_q;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      lap_cnt_q <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      lap_cnt_q <= lap_cnt_d;
      ovf_q     <= ovf_d;
      if (lap_we) lap_mem_q[wr_ptr_q] <= count_q;
    end
  end

  // Newest lap sits one behind the write pointer; lap_sel counts backwards from it.
  assign last_idx = wr_ptr_q - 1'b1;
  assign rd_idx   = wr_ptr_q - 1'b1 - lap_sel;

  assign running  = active;
  assign hold     = (state_q == S_HOLD);
  assign count    = count_q;
  assign disp     = hold ? lap_mem_q[last_idx] : count_q;
  assign lap_data = ({1'b0, lap_sel} < lap_cnt_q) ? lap_mem_q[rd_idx] : '0;
  assign lap_cnt  = lap_cnt_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_ctrl.sv
`default_nettype none
// Testbench for stopwatch_lap_ctrl: scoreboard against a queue-based reference model.
module tb_stopwatch_lap_ctrl;

  localparam int CNT_W = 4;
  localparam int LAP_DEPTH = 4;
  localparam int TICK_DIV = 4;
  localparam int MAXC = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_pause = 1'b0, clear_req = 1'b0, lap_req = 1'b0;
  logic [1:0] lap_sel = '0;
  logic running, hold, ovf;
  logic [CNT_W-1:0] count, disp, lap_data;
  logic [2:0] lap_cnt;

  stopwatch_lap_ctrl #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .start_pause(start_pause), .clear_req(clear_req),
    .lap_req(lap_req), .lap_sel(lap_sel), .running(running), .hold(hold),
    .count(count), .disp(disp), .lap_data(lap_data), .lap_cnt(lap_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int running, hold, count, disp, lap_data, lap_cnt, ovf;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // Reference model: state, tick arithmetic and a newest-first list of laps.
  int m_st, m_cnt, m_pre, m_ovf;
  int m_laps[$];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_ovf = 0;
    m_laps.delete();
  endtask

  task automatic model_step(input bit sp, input bit cl, input bit lr);
    int nst;
    bit act;
    if (cl) begin
      model_reset();
      return;
    end
    act = (m_st == M_RUN) || (m_st == M_HOLD);
    nst = m_st;
    if (sp) begin
      nst = act ? M_PAUSE : M_RUN;
    end else if (lr) begin
      if (m_st == M_RUN) begin
        nst = M_HOLD;
        m_laps.push_front(m_cnt);
        if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_back());
      end else if (m_st == M_HOLD) begin
        nst = M_RUN;
      end
    end
    if (act) begin
      m_pre = (m_pre + 1) % TICK_DIV;
      if (m_pre == 0) begin
        if (m_cnt == MAXC) begin
          m_ovf = 1;
`ifdef STOPWATCH_WRAP_EN
          m_cnt = 0;
`endif
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    m_st = nst;
  endtask

  function automatic exp_t model_out(input int sel);
    exp_t e;
    e.running  = (m_st == M_RUN || m_st == M_HOLD) ? 1 : 0;
    e.hold     = (m_st == M_HOLD) ? 1 : 0;
    e.count    = m_cnt;
    e.disp     = (m_st == M_HOLD) ? m_laps[0] : m_cnt;
    e.lap_data = (sel < m_laps.size()) ? m_laps[sel] : 0;
    e.lap_cnt  = m_laps.size();
    e.ovf      = m_ovf;
    return e;
  endfunction

  task automatic step(input bit sp, input bit cl, input bit lr, input int sel);
    @(negedge clk);
    start_pause = sp; clear_req = cl; lap_req = lr; lap_sel = 2'(sel);
    model_step(sp, cl, lr);
    exp_q.push_back(model_out(sel));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 200 && m_cnt != target; i++) step(0, 0, 0, 0);
    chk("reach_count", m_cnt, target);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start_pause = 0; clear_req = 0; lap_req = 0; lap_sel = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_running", running, 0);
    chk("rst_hold", hold, 0);
    chk("rst_count", count, 0);
    chk("rst_disp", disp, 0);
    chk("rst_lap_data", lap_data, 0);
    chk("rst_lap_cnt", lap_cnt, 0);
    chk("rst_ovf", ovf, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every output is valid each cycle; compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("running", running, e.running);
        chk("hold", hold, e.hold);
        chk("count", count, e.count);
        chk("disp", disp, e.disp);
        chk("lap_data", lap_data, e.lap_data);
        chk("lap_cnt", lap_cnt, e.lap_cnt);
        chk("ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    #1;
    chk("init_count", count, 0);
    chk("init_running", running, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Start, 12 cycles, pause, hold steady.
    step(1, 0, 0, 0);
    idle(12);
    chk("count_after_12", m_cnt, 3);
    step(1, 0, 0, 0);
    idle(20);

    // Lap at 5, frozen display, release.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    run_until(5);
    step(0, 0, 1, 0);
    run_until(7);
    step(0, 0, 1, 0);
    idle(3);

    // Five laps fill and wrap the circular memory.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      run_until(k);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
    end
    for (int s = 0; s < 4; s++) step(0, 0, 0, s);

    // Priority cases.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    idle(3);
    step(1, 1, 0, 0);
    idle(3);

    // Overflow at all-ones.
    step(1, 0, 0, 0);
    run_until(MAXC);
    idle(TICK_DIV + 2);
    for (int s = 0; s < 4; s++) step(0, 0, 0, s);

    // Asynchronous reset mid-prescale in HOLD, then restart.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    idle(6);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    async_reset();
    step(1, 0, 0, 0);
    idle(10);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end

    idle(2);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
